// File: rtl/control_sequencer.sv
// control_sequencer: Moore control unit for the Mini SRC datapath.
// Steps each instruction through fetch (T0-T2) and execute (T3-T7) and
// drives the register-select, bus, ALU and memory strobes from state + opcode.
// Optional feature: define MEM_WAIT_EN to stall fetch T1, ld T6 and st T7
// until mem_ready is high. Without it mem_ready is ignored.
module control_sequencer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        baout,
  output logic        pc_out,
  output logic        pc_in,
  output logic        inc_pc,
  output logic        mar_in,
  output logic        mdr_in,
  output logic        mdr_out,
  output logic        ir_in,
  output logic        y_in,
  output logic        z_in,
  output logic        zlow_out,
  output logic        c_out,
  output logic        read,
  output logic        write,
  output logic [3:0]  alu_op,
  output logic        halted,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    T7   = 4'd8,
    HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;

  state_t     state, state_nxt;
  logic [4:0] opcode;
  logic       mem_wait;

  // instruction classes
  logic       is_reg_alu, is_imm_alu, is_ldi, is_ld, is_st, is_nop, is_halt;
  logic       is_legal;
  logic [3:0] op_alu;

  assign opcode = ir[31:27];

`ifdef MEM_WAIT_EN
  assign mem_wait = ~mem_ready;
  logic unused_bits;
  assign unused_bits = ^ir[26:0];
`else
  // mem_ready is kept as a port but has no effect in this build
  assign mem_wait = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{ir[26:0], mem_ready};
`endif

  // opcode classification and ALU function select
  always_comb begin
    is_reg_alu = 1'b0;
    is_imm_alu = 1'b0;
    is_ldi     = 1'b0;
    is_ld      = 1'b0;
    is_st      = 1'b0;
    is_nop     = 1'b0;
    is_halt    = 1'b0;
    op_alu     = ALU_ADD;
    case (opcode)
      OP_LD:   is_ld = 1'b1;
      OP_LDI:  is_ldi = 1'b1;
      OP_ST:   is_st = 1'b1;
      OP_ADD:  begin is_reg_alu = 1'b1; op_alu = ALU_ADD; end
      OP_SUB:  begin is_reg_alu = 1'b1; op_alu = ALU_SUB; end
      OP_AND:  begin is_reg_alu = 1'b1; op_alu = ALU_AND; end
      OP_OR:   begin is_reg_alu = 1'b1; op_alu = ALU_OR;  end
      OP_ADDI: begin is_imm_alu = 1'b1; op_alu = ALU_ADD; end
      OP_ANDI: begin is_imm_alu = 1'b1; op_alu = ALU_AND; end
      OP_ORI:  begin is_imm_alu = 1'b1; op_alu = ALU_OR;  end
      OP_NOP:  is_nop = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign is_legal = is_reg_alu | is_imm_alu | is_ldi | is_ld | is_st | is_nop | is_halt;

  // state register; reset forces IDLE, whose decode is all-zero outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: fetch, per-class execute length, memory stalls, end check
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = run ? T0 : IDLE;
      T0:   state_nxt = T1;
      T1:   state_nxt = mem_wait ? T1 : T2;
      T2: begin
        if (is_nop)       state_nxt = T0;
        else if (is_halt) state_nxt = HALT;
        else              state_nxt = T3;
      end
      T3:   state_nxt = is_legal ? T4 : T0;
      T4:   state_nxt = T5;
      T5: begin
        if (is_ld || is_st) state_nxt = T6;
        else                state_nxt = run ? T0 : IDLE;
      end
      T6: begin
        if (is_ld && mem_wait) state_nxt = T6;
        else                   state_nxt = T7;
      end
      T7: begin
        if (is_st && mem_wait) state_nxt = T7;
        else                   state_nxt = run ? T0 : IDLE;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore output decode from state and opcode
  always_comb begin
    gra        = 1'b0;
    grb        = 1'b0;
    grc        = 1'b0;
    rin        = 1'b0;
    rout       = 1'b0;
    baout      = 1'b0;
    pc_out     = 1'b0;
    pc_in      = 1'b0;
    inc_pc     = 1'b0;
    mar_in     = 1'b0;
    mdr_in     = 1'b0;
    mdr_out    = 1'b0;
    ir_in      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    zlow_out   = 1'b0;
    c_out      = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    alu_op     = ALU_ADD;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
      end
      T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      T3: begin
        if (is_reg_alu || is_imm_alu) begin
          grb  = 1'b1;
          rout = 1'b1;
          y_in = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          // base register (or zero when R0) goes to Y as the address base
          grb   = 1'b1;
          baout = 1'b1;
          y_in  = 1'b1;
        end else if (!is_legal) begin
          illegal_op = 1'b1;
        end
      end
      T4: begin
        if (is_reg_alu) begin
          grc    = 1'b1;
          rout   = 1'b1;
          z_in   = 1'b1;
          alu_op = op_alu;
        end else if (is_imm_alu) begin
          c_out  = 1'b1;
          z_in   = 1'b1;
          alu_op = op_alu;
        end else if (is_ldi || is_ld || is_st) begin
          c_out  = 1'b1;
          z_in   = 1'b1;
          alu_op = ALU_ADD;
        end
      end
      T5: begin
        if (is_reg_alu || is_imm_alu || is_ldi) begin
          zlow_out = 1'b1;
          gra      = 1'b1;
          rin      = 1'b1;
        end else if (is_ld || is_st) begin
          zlow_out = 1'b1;
          mar_in   = 1'b1;
        end
      end
      T6: begin
        if (is_ld) begin
          read   = 1'b1;
          mdr_in = 1'b1;
        end else if (is_st) begin
          gra    = 1'b1;
          rout   = 1'b1;
          mdr_in = 1'b1;
        end
      end
      T7: begin
        if (is_ld) begin
          mdr_out = 1'b1;
          gra     = 1'b1;
          rin     = 1'b1;
        end else if (is_st) begin
          write = 1'b1;
        end
      end
      HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed checks of the full output vector per cycle.
// Outputs are sampled 1 time unit after each rising edge.
module tb_control_sequencer;

  logic        clock, reset_n, run, mem_ready;
  logic [31:0] ir;
  logic        gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc;
  logic        mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out;
  logic        read, write, halted, illegal_op;
  logic [3:0]  alu_op;
  logic [24:0] obs;

  int checks = 0;
  int failures = 0;

  localparam logic [24:0] GRA   = 25'h1 << 24;
  localparam logic [24:0] GRB   = 25'h1 << 23;
  localparam logic [24:0] GRC   = 25'h1 << 22;
  localparam logic [24:0] RIN   = 25'h1 << 21;
  localparam logic [24:0] ROUT  = 25'h1 << 20;
  localparam logic [24:0] BAOUT = 25'h1 << 19;
  localparam logic [24:0] PCOUT = 25'h1 << 18;
  localparam logic [24:0] PCIN  = 25'h1 << 17;
  localparam logic [24:0] INCPC = 25'h1 << 16;
  localparam logic [24:0] MARIN = 25'h1 << 15;
  localparam logic [24:0] MDRIN = 25'h1 << 14;
  localparam logic [24:0] MDROUT= 25'h1 << 13;
  localparam logic [24:0] IRIN  = 25'h1 << 12;
  localparam logic [24:0] YIN   = 25'h1 << 11;
  localparam logic [24:0] ZIN   = 25'h1 << 10;
  localparam logic [24:0] ZLOW  = 25'h1 << 9;
  localparam logic [24:0] COUT  = 25'h1 << 8;
  localparam logic [24:0] READ  = 25'h1 << 7;
  localparam logic [24:0] WRITE = 25'h1 << 6;
  localparam logic [24:0] ALU1  = 25'h1 << 2;
  localparam logic [24:0] ALU3  = 25'h3 << 2;
  localparam logic [24:0] HALTD = 25'h1 << 1;
  localparam logic [24:0] ILL   = 25'h1;
  localparam logic [24:0] NONE  = 25'h0;

  localparam logic [24:0] F0 = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [24:0] F1 = ZLOW | PCIN | READ | MDRIN;
  localparam logic [24:0] F2 = MDROUT | IRIN;
  localparam logic [24:0] RA3 = GRB | ROUT | YIN;
  localparam logic [24:0] WB5 = ZLOW | GRA | RIN;
  localparam logic [24:0] BA3 = GRB | BAOUT | YIN;
  localparam logic [24:0] IM4 = COUT | ZIN;
  localparam logic [24:0] AD5 = ZLOW | MARIN;

`ifdef MEM_WAIT_EN
  localparam logic MR_DEF = 1'b1;
`else
  localparam logic MR_DEF = 1'b0;
`endif

  control_sequencer dut (
    .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .gra(gra), .grb(grb), .grc(grc), .rin(rin), .rout(rout), .baout(baout),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
    .zlow_out(zlow_out), .c_out(c_out), .read(read), .write(write),
    .alu_op(alu_op), .halted(halted), .illegal_op(illegal_op)
  );

  assign obs = {gra, grb, grc, rin, rout, baout, pc_out, pc_in, inc_pc, mar_in,
                mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out, read, write,
                alu_op, halted, illegal_op};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input logic [24:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [24:0] exp, input string tag);
    @(posedge clock);
    #1;
    chk(exp, tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    run       = 1'b0;
    ir        = 32'h0;
    mem_ready = MR_DEF;
    #12;
    chk(NONE, "reset_state");
    reset_n = 1'b1;
    tick(NONE, "idle_hold");

    // add r1,r2,r3
    run = 1'b1;
    ir  = 32'h1891_8000;
    tick(F0,  "add_t0");
    tick(F1,  "add_t1");
    tick(F2,  "add_t2");
    tick(RA3, "add_t3");
    tick(GRC | ROUT | ZIN, "add_t4");
    tick(WB5, "add_t5");
    tick(F0,  "add_back_t0");

    // sub: ALU op 1
    ir = 32'h2000_0000;
    tick(F1,  "sub_t1");
    tick(F2,  "sub_t2");
    tick(RA3, "sub_t3");
    tick(GRC | ROUT | ZIN | ALU1, "sub_t4");
    tick(WB5, "sub_t5");
    tick(F0,  "sub_t0");

    // ori: immediate, ALU op 3
    ir = 32'h7000_0000;
    tick(F1,  "ori_t1");
    tick(F2,  "ori_t2");
    tick(RA3, "ori_t3");
    tick(IM4 | ALU3, "ori_t4");
    tick(WB5, "ori_t5");
    tick(F0,  "ori_t0");

    // ldi
    ir = 32'h0800_0000;
    tick(F1,  "ldi_t1");
    tick(F2,  "ldi_t2");
    tick(BA3, "ldi_t3");
    tick(IM4, "ldi_t4");
    tick(WB5, "ldi_t5");
    tick(F0,  "ldi_t0");

    // ld r4; run dropped mid-instruction must not abort it
    ir = 32'h0200_0000;
    tick(F1,  "ld_t1");
    run = 1'b0;
    tick(F2,  "ld_t2");
    tick(BA3, "ld_t3");
    tick(IM4, "ld_t4");
    tick(AD5, "ld_t5");
`ifdef MEM_WAIT_EN
    mem_ready = 1'b0;
    tick(READ | MDRIN, "ld_t6_w0");
    tick(READ | MDRIN, "ld_t6_w1");
    tick(READ | MDRIN, "ld_t6_w2");
    tick(READ | MDRIN, "ld_t6_w3");
    mem_ready = 1'b1;
`else
    tick(READ | MDRIN, "ld_t6");
`endif
    tick(MDROUT | GRA | RIN, "ld_t7");
    tick(NONE, "ld_end_idle");
    tick(NONE, "idle_stay");

    // st with mem_ready low (ignored without the stall feature)
    run = 1'b1;
    ir  = 32'h1000_0000;
    mem_ready = MR_DEF;
    tick(F0,  "st_t0");
    tick(F1,  "st_t1");
    tick(F2,  "st_t2");
    tick(BA3, "st_t3");
    tick(IM4, "st_t4");
    tick(AD5, "st_t5");
    tick(GRA | ROUT | MDRIN, "st_t6");
    tick(WRITE, "st_t7");
    tick(F0,  "st_after_t0");

    // nop: straight back to T0 after T2
    ir = 32'hD000_0000;
    tick(F1, "nop_t1");
    tick(F2, "nop_t2");
    tick(F0, "nop_t0");

    // undefined opcode 11111
    ir = 32'hF800_0000;
    tick(F1,  "ill_t1");
    tick(F2,  "ill_t2");
    tick(ILL, "ill_t3");
    tick(F0,  "ill_t0");

    // reset asserted during ld T5
    ir = 32'h0200_0000;
    tick(F1,  "ldr_t1");
    tick(F2,  "ldr_t2");
    tick(BA3, "ldr_t3");
    tick(IM4, "ldr_t4");
    tick(AD5, "ldr_t5");
    #2;
    reset_n = 1'b0;
    #1;
    chk(NONE, "async_reset");
    #2;
    reset_n = 1'b1;
    tick(F0, "post_reset_t0");

    // halt: holds forever until reset
    ir = 32'hD800_0000;
    tick(F1, "halt_t1");
    tick(F2, "halt_t2");
    for (int i = 0; i < 20; i++) tick(HALTD, "halt_hold");
    #2;
    reset_n = 1'b0;
    #1;
    chk(NONE, "halt_reset");
    run = 1'b0;
    #2;
    reset_n = 1'b1;
    tick(NONE, "halt_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
